// File: rtl/minimig_sram_responder.sv
// Board-side responder for the chipset SRAM bridge: captures async-SRAM-style
// accesses and services them from a synchronous backend over a req/ack handshake.
module minimig_sram_responder #(
   parameter int DEADLINE = 3
) (
   input  logic        clk,
   input  logic        _reset,
   input  logic        _oe,
   input  logic        _we,
   input  logic        _bhe,
   input  logic        _ble,
   input  logic [22:1] address,
   input  logic [15:0] data,
   output logic [15:0] ramdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [22:1] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [3:0] DEADLINE_W = 4'(DEADLINE);

   state_t      state, state_next;
   logic        access;
   logic        is_write;
   logic        null_write;
   logic        changed;
   logic        capture;
   logic [2:0]  cnt;
   logic [3:0]  cnt_inc;

   always_ff @(posedge clk) begin
      if (!_reset) state <= IDLE;
      else         state <= state_next;
   end

   // A write with both byte lanes disabled is captured but never reaches the backend.
   always_comb begin
      access     = !_we || !_oe;
      is_write   = !_we;
      null_write = is_write && _bhe && _ble;
      changed    = (address != mem_addr) || (is_write != mem_we);
      cnt_inc    = {1'b0, cnt} + 4'd1;
      capture    = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            if (access) begin
               capture    = 1'b1;
               state_next = null_write ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_ack) state_next = DONE;
         end
         DONE: begin
            if (!access) begin
               state_next = IDLE;
            end else if (changed) begin
               capture    = 1'b1;
               state_next = null_write ? DONE : REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ramdata   <= '0;
         overrun   <= 1'b0;
         cnt       <= '0;
      end else if (capture) begin
         mem_addr  <= address;
         mem_wdata <= data;
         mem_we    <= is_write;
         mem_be    <= is_write ? {!_bhe, !_ble} : 2'b11;
         mem_req   <= !null_write;
         cnt       <= '0;
      end else if (state == REQ) begin
         if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) ramdata <= mem_rdata;
         end else begin
            if (cnt != 3'd7) cnt <= cnt_inc[2:0];
            if (cnt_inc >= DEADLINE_W) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_minimig_sram_responder.sv
// Self-checking bench for minimig_sram_responder: directed scenarios plus
// randomized accesses checked against a transaction-level model of the port.
module tb_minimig_sram_responder;

   localparam int DEADLINE = 3;

   logic        clk = 1'b0;
   logic        _reset, _oe, _we, _bhe, _ble;
   logic [22:1] address;
   logic [15:0] data;
   logic [15:0] ramdata;
   logic        mem_req, mem_we;
   logic [1:0]  mem_be;
   logic [22:1] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_ramdata = '0;
   logic        exp_overrun = 1'b0;

   always #18 clk = ~clk;

   minimig_sram_responder #(.DEADLINE(DEADLINE)) dut (
      .clk(clk), ._reset(_reset), ._oe(_oe), ._we(_we), ._bhe(_bhe), ._ble(_ble),
      .address(address), .data(data), .ramdata(ramdata), .mem_req(mem_req),
      .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .overrun(overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generic access: drive strobes, wait `delay` REQ cycles, ack, hold, release.
   task automatic do_access(input string name, input logic we_n, input logic oe_n,
                            input logic bhe_n, input logic ble_n, input logic [22:1] addr,
                            input logic [15:0] wdata, input int delay,
                            input logic [15:0] rdata, input int hold);
      logic is_wr, is_null;
      logic [1:0] ebe;
      logic [41:0] exp_bus;
      logic want_ov;
      is_wr   = !we_n;
      is_null = is_wr && bhe_n && ble_n;
      ebe     = is_wr ? {!bhe_n, !ble_n} : 2'b11;
      exp_bus = {1'b1, is_wr, ebe, addr, wdata};
      _we = we_n; _oe = oe_n; _bhe = bhe_n; _ble = ble_n;
      address = addr; data = wdata; mem_rdata = 16'($urandom);
      tick();
      if (is_null) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b0) begin
               failures++;
               $display("FAIL %s null_req cyc%0d: got %b want 0", name, i, mem_req);
            end
            tick();
         end
      end else begin
         for (int k = 0; k <= delay; k++) begin
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== exp_bus) begin
               failures++;
               $display("FAIL %s bus k=%0d: got %h want %h", name, k,
                        {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, exp_bus);
            end
            want_ov = exp_overrun || (k >= DEADLINE);
            checks++;
            if (overrun !== want_ov) begin
               failures++;
               $display("FAIL %s overrun k=%0d: got %b want %b", name, k, overrun, want_ov);
            end
            if (k < delay) begin
               address = 22'($urandom); data = 16'($urandom); mem_rdata = 16'($urandom);
               tick();
            end
         end
         exp_overrun = exp_overrun || (delay >= DEADLINE);
         address = addr; data = wdata;
         mem_ack = 1'b1; mem_rdata = rdata;
         tick();
         mem_ack = 1'b0;
         if (!is_wr) exp_ramdata = rdata;
         checks++;
         if ({mem_req, ramdata, overrun} !== {1'b0, exp_ramdata, exp_overrun}) begin
            failures++;
            $display("FAIL %s ack: got req=%b ramdata=%h ov=%b want req=0 ramdata=%h ov=%b",
                     name, mem_req, ramdata, overrun, exp_ramdata, exp_overrun);
         end
      end
      for (int i = 0; i < hold; i++) begin
         mem_rdata = 16'($urandom);
         tick();
         checks++;
         if ({mem_req, ramdata} !== {1'b0, exp_ramdata}) begin
            failures++;
            $display("FAIL %s hold cyc%0d: got req=%b ramdata=%h want req=0 ramdata=%h",
                     name, i, mem_req, ramdata, exp_ramdata);
         end
      end
      _we = 1'b1; _oe = 1'b1;
      tick();
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL %s release: got req=%b want 0", name, mem_req);
      end
   endtask

   task automatic test_reset();
      _reset = 1'b0; _oe = 1'b1; _we = 1'b1; _bhe = 1'b1; _ble = 1'b1;
      address = '0; data = '0; mem_rdata = '0; mem_ack = 1'b0;
      tick(); tick();
      exp_ramdata = '0; exp_overrun = 1'b0;
      checks++;
      if ({ramdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, overrun} !== 59'd0) begin
         failures++;
         $display("FAIL reset_values: got %h want 0",
                  {ramdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, overrun});
      end
      _reset = 1'b1;
      tick();
   endtask

   task automatic test_read_zero_wait();
      do_access("read_zero_wait", 1'b1, 1'b0, 1'b0, 1'b1, 22'h000123, 16'h5555, 0, 16'hBEEF, 2);
   endtask

   task automatic test_byte_write();
      do_access("byte_write", 1'b0, 1'b1, 1'b1, 1'b0, 22'h3FFFFF, 16'h12AB, 0,
                16'($urandom), 8);
   endtask

   task automatic test_back_to_back();
      logic [15:0] r1, r2;
      r1 = 16'($urandom); r2 = 16'($urandom);
      _oe = 1'b0; _we = 1'b1; address = 22'h10;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 22'h10}) begin
         failures++;
         $display("FAIL b2b first_req: got req=%b addr=%h want req=1 addr=10", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = r1;
      tick();
      mem_ack = 1'b0;
      exp_ramdata = r1;
      checks++;
      if ({mem_req, ramdata} !== {1'b0, r1}) begin
         failures++;
         $display("FAIL b2b gap: got req=%b ramdata=%h want req=0 ramdata=%h", mem_req, ramdata, r1);
      end
      address = 22'h11;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 22'h11}) begin
         failures++;
         $display("FAIL b2b second_req: got req=%b addr=%h want req=1 addr=11", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = r2;
      tick();
      mem_ack = 1'b0;
      exp_ramdata = r2;
      checks++;
      if ({mem_req, ramdata} !== {1'b0, r2}) begin
         failures++;
         $display("FAIL b2b second_ack: got req=%b ramdata=%h want req=0 ramdata=%h",
                  mem_req, ramdata, r2);
      end
      _oe = 1'b1;
      tick();
   endtask

   task automatic test_write_priority();
      do_access("write_priority", 1'b0, 1'b0, 1'b0, 1'b0, 22'h0ABCDE, 16'hA5C3, 1,
                16'($urandom), 1);
   endtask

   task automatic test_null_write();
      do_access("null_write", 1'b0, 1'b1, 1'b1, 1'b1, 22'h001234, 16'hFFFF, 0, 16'h0, 0);
   endtask

   task automatic test_slow_backend();
      do_access("slow_backend", 1'b1, 1'b0, 1'b1, 1'b1, 22'h2AAAAA, 16'h0, 4, 16'hC0DE, 1);
      do_access("after_overrun", 1'b1, 1'b0, 1'b0, 1'b0, 22'h000777, 16'h0, 0, 16'h7777, 0);
   endtask

   task automatic test_reset_mid_req();
      _oe = 1'b0; _we = 1'b1; address = 22'h155555;
      tick(); tick();
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid pre_req: got %b want 1", mem_req);
      end
      _reset = 1'b0; _oe = 1'b1;
      tick();
      exp_ramdata = '0; exp_overrun = 1'b0;
      checks++;
      if ({ramdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, overrun} !== 59'd0) begin
         failures++;
         $display("FAIL rst_mid values: got %h want 0",
                  {ramdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, overrun});
      end
      _reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, ramdata} !== {1'b0, 16'h0}) begin
         failures++;
         $display("FAIL rst_mid late_ack: got req=%b ramdata=%h want req=0 ramdata=0",
                  mem_req, ramdata);
      end
      _reset = 1'b0; _oe = 1'b0; address = 22'h00002A;
      tick();
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL rst_held_strobe: got req=%b want 0", mem_req);
      end
      _reset = 1'b1;
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 22'h00002A}) begin
         failures++;
         $display("FAIL rst_release_capture: got req=%b addr=%h want req=1 addr=2a",
                  mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 16'h4242;
      tick();
      mem_ack = 1'b0;
      exp_ramdata = 16'h4242;
      checks++;
      if (ramdata !== exp_ramdata) begin
         failures++;
         $display("FAIL rst_release_read: got %h want %h", ramdata, exp_ramdata);
      end
      _oe = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int mode;
      logic we_n, oe_n;
      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 2);
         we_n = (mode == 0);
         oe_n = (mode == 1);
         do_access("random", we_n, oe_n, 1'($urandom), 1'($urandom), 22'($urandom),
                   16'($urandom), $urandom_range(0, 5), 16'($urandom), $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_byte_write();
      test_back_to_back();
      test_write_priority();
      test_null_write();
      test_slow_backend();
      test_reset_mid_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/minimig_sram_responder.md
# minimig_sram_responder

Board-side responder for the chipset's asynchronous-SRAM-style memory port: it watches the active-low strobes, address and write data that the chipset SRAM bridge drives, and services each access from a synchronous backing memory (block RAM or SDRAM front-end) over a req/ack handshake. It returns read words on `ramdata`, which connects to the bridge's `ramdata_in`. It also flags accesses the backend could not serve within the chipset bus-cycle budget.

## Interface
- `DEADLINE`, default 3: clk cycles from access capture to `mem_ack` before `overrun` is set.
- `clk` in 1: 28 MHz system clock.
- `_reset` in 1: synchronous, active-low reset.
- `_oe` in 1: active-low read strobe.
- `_we` in 1: active-low write strobe.
- `_bhe` in 1: active-low upper byte enable.
- `_ble` in 1: active-low lower byte enable.
- `address` in 22 `[22:1]`: word address.
- `data` in 16: write data from the chipset.
- `ramdata` out 16: read data returned to the chipset, registered.
- `mem_req` out 1: backend request, held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_be` out 2: byte enables `{upper, lower}`, active-high.
- `mem_addr` out 22: latched word address.
- `mem_wdata` out 16: latched write data.
- `mem_rdata` in 16: backend read data, valid while `mem_ack` = 1 on a read.
- `mem_ack` in 1: backend acknowledge, single-cycle pulse.
- `overrun` out 1: sticky deadline-miss flag.

## Operation
- FSM states: IDLE, REQ, DONE.
- An access is active when `_we` = 0, or when `_oe` = 0.
- Writes with `_bhe` = `_ble` = 1 are no-ops: no request is issued, and the FSM goes from IDLE directly to DONE.
- If `_we` and `_oe` are both low, the access is a write (SRAM semantics).
- Reads always fetch the full word, with `mem_be` = 2'b11. `_bhe`/`_ble` are ignored on reads.
- Write `mem_be` = `{~_bhe, ~_ble}`.
- IDLE → REQ: on a clk edge with an active access. At that edge:
  - latch `address`, `data`, the type and the byte enables into the `mem_*` outputs;
  - set `mem_req` = 1;
  - clear the deadline counter.
- REQ:
  - `mem_req` and all `mem_*` outputs hold stable until `mem_ack` is sampled high.
  - On the ack edge: `mem_req` → 0, and the FSM goes to DONE.
  - On a read, `ramdata` ← `mem_rdata` at the same edge.
  - Strobe or address changes while in REQ are ignored; the latched access completes.
- DONE → IDLE: when both `_oe` and `_we` are high.
- DONE → REQ: when the strobes are still active but `address` or the access type differs from the latched values (back-to-back access). The new access is latched exactly as in IDLE → REQ.
- DONE, strobes active and access unchanged: stay in DONE; the access is not repeated.
- Deadline counter:
  - 3 bits, saturating; increments each cycle in REQ.
  - If it reaches `DEADLINE` without an ack, set `overrun` = 1. The request still completes normally.
  - `overrun` is cleared only by reset.
- `ramdata` holds its last value between reads. It is unaffected by writes, including writes to the same address; the next read fetches fresh data.
- Reset values: FSM IDLE, `mem_req` 0, `mem_we` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0, `ramdata` 0, `overrun` 0, counter 0.
- Reset during REQ: `mem_req` drops on the reset edge. A late `mem_ack` arriving after reset is ignored (the FSM is in IDLE).
- If a strobe is low when reset releases, the access is captured at the first non-reset edge.

## Timing
- An access is sampled at edge t; `mem_req` = 1 after t.
- With a zero-wait backend (`mem_ack` in the first REQ cycle, t+1), the ack edge is t+1, `mem_req` = 0 after t+1, and `ramdata` is valid after t+1. That is 2 clks from strobe to data, inside the 4-clk chipset bus cycle.
- In general, with ack sampled at edge k, `ramdata` is valid from k onward.
- `overrun` rises at edge t + `DEADLINE` if no ack has been sampled at or before that edge.
- The minimum spacing between back-to-back requests is 1 idle clk of `mem_req` low (the DONE cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Read, zero-wait backend:
  - stimulus: `_oe`=0, `address`=22'h000123, `mem_rdata`=16'hBEEF, ack at the first REQ cycle;
  - required: one `mem_req` pulse with `mem_we`=0, `mem_be`=2'b11, `ramdata`=16'hBEEF 2 clks after the strobe, `overrun`=0.
- Byte write:
  - stimulus: `_we`=0, `_bhe`=1, `_ble`=0, `data`=16'h12AB, `address`=22'h3FFFFF;
  - required: `mem_we`=1, `mem_be`=2'b01, `mem_wdata`=16'h12AB, `mem_addr`=22'h3FFFFF, exactly one request while the strobe is held 8 clks.
- Slow backend:
  - stimulus: ack 5 cycles after `mem_req` rises, `DEADLINE`=3;
  - required: `overrun`=1 three clks after capture, the read still completes with correct `ramdata`, and `overrun` stays 1 afterwards.
- Back-to-back:
  - stimulus: `_oe` held low while `address` steps 0x10 → 0x11;
  - required: two requests with addresses 0x10 then 0x11, and `mem_req` low for ≥1 clk between them.
- Write priority and null write:
  - stimulus: `_oe`=`_we`=0 → a write is issued;
  - stimulus: `_we`=0 with `_bhe`=`_ble`=1 → no `mem_req`.
- Reset mid-REQ:
  - stimulus: `_reset`=0 while `mem_req`=1, then a late ack;
  - required: all outputs at reset values, and the late ack causes no `ramdata` change.
